secuenciador_instr: RTL

Instruction sequencer that feeds the ALU's 8-bit instruction input. It holds a small writable program memory, a program counter, and a run/step/stop state machine. It emits one instruction per step request, or one every `PERIODO` clock cycles in run mode. The output register holds the last issued instruction, so the register bank and operation unit downstream see a stable word between issues.

---
 rtl/secuenciador_instr_pkg.sv | 14 +
 rtl/secuenciador_instr_detector_flanco.sv | 21 ++
 rtl/secuenciador_instr.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/secuenciador_instr_pkg.sv
// Shared definitions for the instruction sequencer: state encoding and
// defaults common with the ALU top.
package secuenciador_instr_pkg;

    localparam int unsigned TaminstrDef = 8;
    localparam logic [7:0]  FinProgDef  = 8'hFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } estado_e;

endpackage

// File: rtl/secuenciador_instr_detector_flanco.sv
// Rising-edge detector: one sample flop plus an AND gate; the flop resets to 0.
module detector_flanco (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic senal_i,
    output logic flanco_o
);

    logic previo_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            previo_q <= 1'b0;
        end else begin
            previo_q <= senal_i;
        end
    end

    assign flanco_o = senal_i & ~previo_q;

endmodule

// File: rtl/secuenciador_instr.sv
// Instruction sequencer: writable program memory, program counter and an
// IDLE/RUN/HALT machine issuing one word per step or every PERIODO cycles.
module secuenciador_instr
    import secuenciador_instr_pkg::*;
#(
    parameter int unsigned         Taminstr = TaminstrDef,
    parameter int unsigned         Prof     = 16,
    parameter int unsigned         AnchoDir = 4,
    parameter int unsigned         PERIODO  = 4,
    parameter logic [Taminstr-1:0] FIN_PROG = FinProgDef
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                carga_en,
    input  logic [AnchoDir-1:0] carga_dir,
    input  logic [Taminstr-1:0] carga_dato,
    input  logic                run,
    input  logic                step,
    input  logic                parar,
    output logic [Taminstr-1:0] instruccion,
    output logic                instr_valida,
    output logic [AnchoDir-1:0] pc,
    output logic                corriendo,
    output logic                detenido
);

    localparam int unsigned AnchoCont = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam logic [AnchoCont-1:0] ContFin = AnchoCont'(PERIODO - 1);

    logic run_fl, step_fl, parar_fl;

    detector_flanco u_flanco_run (
        .clk_i    (clk),
        .rst_ni   (reset),
        .senal_i  (run),
        .flanco_o (run_fl)
    );

    detector_flanco u_flanco_step (
        .clk_i    (clk),
        .rst_ni   (reset),
        .senal_i  (step),
        .flanco_o (step_fl)
    );

    detector_flanco u_flanco_parar (
        .clk_i    (clk),
        .rst_ni   (reset),
        .senal_i  (parar),
        .flanco_o (parar_fl)
    );

    estado_e              estado_q;
    logic [AnchoCont-1:0] contador_q;
    logic [AnchoDir-1:0]  pc_q;
    logic [Taminstr-1:0]  instruccion_q;
    logic                 instr_valida_q;
    logic                 corriendo_q;
    logic                 detenido_q;

    // Program memory survives reset, so it has no reset branch.
    logic [Taminstr-1:0] mem_q [Prof];
    logic [Taminstr-1:0] palabra;
    logic                es_fin;

    always_ff @(posedge clk) begin
        if (carga_en && (estado_q != StRun)) begin
            mem_q[carga_dir] <= carga_dato;
        end
    end

    assign palabra = mem_q[pc_q];
    assign es_fin  = (palabra == FIN_PROG);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q       <= StIdle;
            contador_q     <= '0;
            pc_q           <= '0;
            instruccion_q  <= '0;
            instr_valida_q <= 1'b0;
            corriendo_q    <= 1'b0;
            detenido_q     <= 1'b0;
        end else begin
            instr_valida_q <= 1'b0;
            unique case (estado_q)
                StIdle: begin
                    // parar has no effect here but still masks run/step.
                    if (!parar_fl && run_fl) begin
                        estado_q    <= StRun;
                        contador_q  <= '0;
                        corriendo_q <= 1'b1;
                    end else if (!parar_fl && step_fl) begin
                        if (es_fin) begin
                            estado_q   <= StHalt;
                            detenido_q <= 1'b1;
                        end else begin
                            instruccion_q  <= palabra;
                            instr_valida_q <= 1'b1;
                            pc_q           <= pc_q + 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (parar_fl) begin
                        estado_q    <= StIdle;
                        contador_q  <= '0;
                        corriendo_q <= 1'b0;
                    end else if (contador_q == ContFin) begin
                        contador_q <= '0;
                        if (es_fin) begin
                            estado_q    <= StHalt;
                            corriendo_q <= 1'b0;
                            detenido_q  <= 1'b1;
                        end else begin
                            instruccion_q  <= palabra;
                            instr_valida_q <= 1'b1;
                            pc_q           <= pc_q + 1'b1;
                        end
                    end else begin
                        contador_q <= contador_q + 1'b1;
                    end
                end
                StHalt: begin
                    if (parar_fl) begin
                        estado_q   <= StIdle;
                        pc_q       <= '0;
                        detenido_q <= 1'b0;
                    end
                end
                default: begin
                    estado_q    <= StIdle;
                    corriendo_q <= 1'b0;
                    detenido_q  <= 1'b0;
                end
            endcase
        end
    end

    assign instruccion  = instruccion_q;
    assign instr_valida = instr_valida_q;
    assign pc           = pc_q;
    assign corriendo    = corriendo_q;
    assign detenido     = detenido_q;

endmodule
